jt03_mixer: RTL and testbench

JT03_MIXER -- requirements
Module: jt03_mixer

---
 rtl/jt03_mix_pkg.sv | 18 +
 rtl/jt03_mix_sat.sv | 26 ++
 rtl/jt03_mixer.sv | 136 +++++++++++++
 tb/tb_jt03_mixer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/jt03_mix_pkg.sv
// Shared types and constants for the JT03 FM/PSG output mixer.
// Holds the FSM state encoding and the datapath widths used by every mixer file.
package jt03_mix_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MUL_L,
      MUL_R,
      MUL_P,
      SUM
   } state_t;

   localparam int PSG_MID   = 512;  // PSG level that represents silence
   localparam int GAIN_FRAC = 4;    // fractional bits of the 4.4 gain format
   localparam int TERM_W    = 21;   // width of each scaled contribution
   localparam int SUM_W     = 22;   // width of the unsaturated channel sum

endpackage

// File: rtl/jt03_mix_sat.sv
// Combinational saturator: clamps a SUM_W-bit signed sum into a DW-bit signed sample.
// Requires DW < SUM_W.
module jt03_mix_sat
   import jt03_mix_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic signed [SUM_W-1:0] d,
   output logic signed [DW-1:0]    q
);

   localparam logic signed [DW-1:0] Q_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] Q_MIN = {1'b1, {(DW-1){1'b0}}};

   logic [SUM_W-DW:0] hi;

   assign hi = d[SUM_W-1:DW-1];

   // NOTE: q gets a default before the if, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      q = d[DW-1:0];
      if (!((&hi) || !(|hi)))
         q = d[SUM_W-1] ? Q_MIN : Q_MAX;
   end

endmodule

// File: rtl/jt03_mixer.sv
// FM + PSG stereo mixer for the OPN core: one shared 17x9 signed multiplier walks
// L, R and PSG terms through a short FSM, then the two sums are saturated to DW bits.
module jt03_mixer
   import jt03_mix_pkg::*;
#(
   parameter int PSG_SHIFT = 1,
   parameter int DW        = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cen,
   input  logic signed [15:0]   fm_snd_l,
   input  logic signed [15:0]   fm_snd_r,
   input  logic        [9:0]    psg_snd,
   input  logic                 snd_sample,
   input  logic        [7:0]    fm_gain,
   input  logic        [7:0]    psg_gain,
   output logic signed [DW-1:0] mix_l,
   output logic signed [DW-1:0] mix_r,
   output logic                 mix_valid,
   output logic                 overrun,
   output logic                 busy
);

   state_t state;

   logic               snd_last;
   logic               strobe;

   logic signed [15:0] fm_l_q, fm_r_q;
   logic        [9:0]  psg_q;
   logic        [7:0]  fm_gain_q, psg_gain_q;

   logic signed [10:0] psg_s;
   logic signed [16:0] mul_a;
   logic signed [8:0]  mul_b;
   logic signed [25:0] mul_p;
   logic signed [TERM_W-1:0] fm_term, psg_term;

   logic signed [TERM_W-1:0] tl, tr, tp;
   logic signed [SUM_W-1:0]  sl, sr;
   logic                     out_pend;
   logic signed [DW-1:0]     sat_l, sat_r;

   assign strobe = cen && snd_sample && !snd_last;
   assign busy   = (state != IDLE);

   // Recentre the unsigned PSG level around zero; the 11-bit wrap gives -512..511.
   assign psg_s = $signed({1'b0, psg_q} - 11'(PSG_MID));

   always_comb begin
      mul_a = {fm_l_q[15], fm_l_q};
      mul_b = {1'b0, fm_gain_q};
      case (state)
         MUL_R:   mul_a = {fm_r_q[15], fm_r_q};
         MUL_P: begin
            mul_a = {{6{psg_s[10]}}, psg_s};
            mul_b = {1'b0, psg_gain_q};
         end
         default: ;
      endcase
   end

   assign mul_p    = mul_a * mul_b;
   assign fm_term  = TERM_W'(mul_p >>> GAIN_FRAC);
   assign psg_term = TERM_W'(mul_p >>> PSG_SHIFT);

   jt03_mix_sat #(.DW(DW)) u_sat_l (.d(sl), .q(sat_l));
   jt03_mix_sat #(.DW(DW)) u_sat_r (.d(sr), .q(sat_r));

   // NOTE: all state is written with <= so every register samples pre-edge values,
   // regardless of statement order inside this block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         snd_last   <= 1'b0;
         fm_l_q     <= '0;
         fm_r_q     <= '0;
         psg_q      <= '0;
         fm_gain_q  <= '0;
         psg_gain_q <= '0;
         tl         <= '0;
         tr         <= '0;
         tp         <= '0;
         sl         <= '0;
         sr         <= '0;
         out_pend   <= 1'b0;
         mix_l      <= '0;
         mix_r      <= '0;
         mix_valid  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         mix_valid <= out_pend;
         out_pend  <= 1'b0;
         if (cen)
            snd_last <= snd_sample;
         if (out_pend) begin
            mix_l <= sat_l;
            mix_r <= sat_r;
         end
         if (strobe && state != IDLE)
            overrun <= 1'b1;

         case (state)
            IDLE: if (strobe) begin
               fm_l_q     <= fm_snd_l;
               fm_r_q     <= fm_snd_r;
               psg_q      <= psg_snd;
               fm_gain_q  <= fm_gain;
               psg_gain_q <= psg_gain;
               state      <= MUL_L;
            end
            MUL_L: begin
               tl    <= fm_term;
               state <= MUL_R;
            end
            MUL_R: begin
               tr    <= fm_term;
               state <= MUL_P;
            end
            MUL_P: begin
               tp    <= psg_term;
               state <= SUM;
            end
            SUM: begin
               sl       <= SUM_W'(tl) + SUM_W'(tp);
               sr       <= SUM_W'(tr) + SUM_W'(tp);
               out_pend <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jt03_mixer.sv
// Directed self-checking bench for jt03_mixer: arithmetic, saturation, latency,
// overrun, mid-operation reset and cen-qualified strobe detection.
module tb_jt03_mixer;

   localparam int DW = 16;

   logic                 clk = 1'b0;
   logic                 rst, cen, snd_sample;
   logic signed [15:0]   fm_snd_l, fm_snd_r;
   logic        [9:0]    psg_snd;
   logic        [7:0]    fm_gain, psg_gain;
   logic signed [DW-1:0] mix_l, mix_r;
   logic                 mix_valid, overrun, busy;

   int checks    = 0;
   int errors    = 0;
   int valid_cnt = 0;
   int snap;

   jt03_mixer #(.PSG_SHIFT(1), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .cen        (cen),
      .fm_snd_l   (fm_snd_l),
      .fm_snd_r   (fm_snd_r),
      .psg_snd    (psg_snd),
      .snd_sample (snd_sample),
      .fm_gain    (fm_gain),
      .psg_gain   (psg_gain),
      .mix_l      (mix_l),
      .mix_r      (mix_r),
      .mix_valid  (mix_valid),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (mix_valid === 1'b1) valid_cnt++;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int l, input int r, input int p, input int fg, input int pg);
      fm_snd_l = 16'(l);
      fm_snd_r = 16'(r);
      psg_snd  = 10'(p);
      fm_gain  = 8'(fg);
      psg_gain = 8'(pg);
   endtask

   // Raise the strobe at the current negedge, let the capture edge pass, then
   // lower it and scramble every input so the in-flight sample must use held copies.
   task automatic strobe_now();
      snd_sample = 1'b1;
      @(posedge clk);
      @(negedge clk);
      snd_sample = 1'b0;
      drive(32767, -32768, 1023, 255, 255);
   endtask

   // Entered at a negedge lat0 clocks after the capture edge.
   task automatic wait_valid(input string tag, input int lat0, input int exp_l, input int exp_r);
      int lat = lat0;
      while (mix_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, lat, 5);
      check({tag, " mix_l"}, mix_l, exp_l);
      check({tag, " mix_r"}, mix_r, exp_r);
      @(negedge clk);
      check({tag, " pulse width"}, mix_valid, 0);
      check({tag, " hold"}, mix_l, exp_l);
   endtask

   task automatic run(input string tag, input int l, input int r, input int p,
                      input int fg, input int pg, input int exp_l, input int exp_r);
      @(negedge clk);
      drive(l, r, p, fg, pg);
      strobe_now();
      check({tag, " busy"}, busy, 1);
      wait_valid(tag, 0, exp_l, exp_r);
   endtask

   initial begin
      rst        = 1'b1;
      cen        = 1'b1;
      snd_sample = 1'b0;
      drive(0, 0, 512, 0, 0);
      repeat (3) @(negedge clk);
      check("rst mix_l", mix_l, 0);
      check("rst mix_r", mix_r, 0);
      check("rst mix_valid", mix_valid, 0);
      check("rst overrun", overrun, 0);
      check("rst busy", busy, 0);
      rst = 1'b0;

      run("unity", 1000, -1000, 512, 8'h10, 8'h10, 1000, -1000);
      run("psg max", 0, 0, 1023, 8'h10, 8'h10, 4088, 4088);
      run("psg min", 0, 0, 0, 8'h10, 8'h10, -4096, -4096);
      run("saturate", 30000, -30000, 512, 8'h20, 8'h10, 32767, -32768);
      // tl=-480000>>>4=-30000, tr=296280>>>4=18517, tp=188*48>>>1=4512
      run("mixed", -20000, 12345, 700, 8'h18, 8'h30, -25488, 23029);
      // tl=-40>>>4=-3, tr=40>>>4=2, tp=-1>>>1=-1: arithmetic shifts floor
      run("floor", -5, 5, 511, 8'h08, 8'h01, -4, 1);
      run("gain zero", 12000, -7000, 1023, 8'h00, 8'h00, 0, 0);
      check("no overrun yet", overrun, 0);

      // Second strobe two clocks after the first: dropped, overrun latches.
      snap = valid_cnt;
      @(negedge clk);
      drive(100, 200, 512, 8'h10, 8'h10);
      strobe_now();
      @(negedge clk);
      drive(5555, -5555, 900, 8'h10, 8'h10);
      snd_sample = 1'b1;
      @(negedge clk);
      snd_sample = 1'b0;
      check("ovr flag", overrun, 1);
      wait_valid("ovr", 2, 100, 200);
      repeat (8) @(negedge clk);
      check("ovr single valid", valid_cnt - snap, 1);
      check("ovr held", overrun, 1);
      check("ovr idle", busy, 0);

      // Reset while in MUL_R aborts the sample and clears overrun.
      snap = valid_cnt;
      @(negedge clk);
      drive(3000, 3000, 512, 8'h10, 8'h10);
      strobe_now();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("abort no valid", valid_cnt - snap, 0);
      check("abort mix_l", mix_l, 0);
      check("abort mix_r", mix_r, 0);
      check("abort busy", busy, 0);
      check("abort overrun", overrun, 0);
      run("post reset", -1234, 4321, 512, 8'h10, 8'h10, -1234, 4321);

      // Strobe landing on the SUM->IDLE edge is dropped.
      snap = valid_cnt;
      @(negedge clk);
      drive(-700, 800, 512, 8'h10, 8'h10);
      strobe_now();
      repeat (3) @(negedge clk);
      check("sum edge busy", busy, 1);
      drive(9999, 9999, 512, 8'h10, 8'h10);
      snd_sample = 1'b1;
      @(negedge clk);
      snd_sample = 1'b0;
      check("sum edge dropped", busy, 0);
      wait_valid("sum edge", 4, -700, 800);
      repeat (8) @(negedge clk);
      check("sum edge single valid", valid_cnt - snap, 1);
      check("sum edge overrun", overrun, 1);

      // Rising edge while cen=0 is not a strobe until a cen=1 cycle.
      snap = valid_cnt;
      @(negedge clk);
      cen = 1'b0;
      drive(2000, -3000, 612, 8'h10, 8'h08);
      snd_sample = 1'b1;
      repeat (3) @(negedge clk);
      check("cen low no capture", busy, 0);
      cen = 1'b1;
      @(negedge clk);
      check("cen high capture", busy, 1);
      drive(0, 0, 512, 8'h00, 8'h00);
      for (int i = 0; i < 12; i++) begin
         cen = ~cen;
         @(negedge clk);
      end
      check("held high one capture", valid_cnt - snap, 1);
      check("cen mix_l", mix_l, 2400);
      check("cen mix_r", mix_r, -2600);
      check("held high idle", busy, 0);
      cen        = 1'b1;
      snd_sample = 1'b0;
      run("re-arm", 50, -60, 512, 8'h10, 8'h10, 50, -60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
